// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: round-robin sequencer of HDD/floppy block requests onto the
// per-drive sd_rd/sd_wr/sd_ack handshake of hps_io, with an ack timeout abort.
module sd_req_arbiter #(
  parameter int              NREQ      = 3,
  parameter int              TIMEOUT   = 2**22,
  parameter logic [NREQ-1:0] WAIT_MASK = NREQ'(1)
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_rd,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ*32-1:0]        req_lba,
  output logic [NREQ*32-1:0]        sd_lba,
  output logic [NREQ-1:0]           sd_rd,
  output logic [NREQ-1:0]           sd_wr,
  input  logic [NREQ-1:0]           sd_ack,
  output logic [NREQ-1:0]           busy,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           err,
  output logic [$clog2(NREQ)-1:0]   grant,
  output logic                      cpu_wait
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, XFER, FIN, ABORT} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] prd, pwr, old_ack;
  logic [NREQ-1:0] gnt_oh, clr_rd, clr_wr;
  logic            op_wr;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic [GW-1:0]   pick, idx;
  logic            pick_vld;
  logic            ack_rise, ack_fall, closing;

  assign busy     = prd | pwr;
  assign cpu_wait = |(busy & WAIT_MASK);
  assign gnt_oh   = NREQ'(1) << grant;
  assign ack_rise = sd_ack[grant] & ~old_ack[grant];
  assign ack_fall = ~sd_ack[grant] & old_ack[grant];
  assign closing  = (state == FIN) || (state == ABORT);

  assign sd_rd  = (state == ISSUE && !op_wr) ? gnt_oh : '0;
  assign sd_wr  = (state == ISSUE &&  op_wr) ? gnt_oh : '0;
  assign done   = (state == FIN)   ? gnt_oh : '0;
  assign err    = (state == ABORT) ? gnt_oh : '0;
  assign clr_rd = (closing && !op_wr) ? gnt_oh : '0;
  assign clr_wr = (closing &&  op_wr) ? gnt_oh : '0;

  // First busy drive after the last one served, wrapping modulo NREQ.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pick     = grant;
    pick_vld = 1'b0;
    idx      = grant;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(grant) + k) % NREQ);
      if (!pick_vld && busy[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (pick_vld) state_nxt = ISSUE;
      ISSUE:      if (tmo_hit) state_nxt = ABORT; else if (ack_rise) state_nxt = XFER;
      XFER:       if (tmo_hit) state_nxt = ABORT; else if (ack_fall) state_nxt = FIN;
      FIN, ABORT: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prd     <= '0;
      pwr     <= '0;
      old_ack <= '0;
      grant   <= GW'(NREQ - 1);
      op_wr   <= 1'b0;
      tmo_cnt <= '0;
      tmo_hit <= 1'b0;
    end else begin
      old_ack <= sd_ack;
      // A pulse in the cycle its bit is being retired keeps the bit set.
      prd     <= (prd & ~clr_rd) | req_rd;
      pwr     <= (pwr & ~clr_wr) | req_wr;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        tmo_hit <= 1'b0;
        if (pick_vld) begin
          grant <= pick;
          op_wr <= ~prd[pick];
        end
      end else if (state == ISSUE || state == XFER) begin
        // Terminal count is registered, so the abort lands one cycle after it.
        tmo_cnt <= tmo_cnt + 1'b1;
        tmo_hit <= (tmo_cnt == CW'(TIMEOUT - 1));
      end else begin
        tmo_hit <= 1'b0;
      end
    end
  end

  // NOTE: sd_lba is a small register bank rather than a RAM; it is reset because hps_io reads it directly.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sd_lba <= '0;
    end else if (state == IDLE && pick_vld) begin
      for (int i = 0; i < NREQ; i++)
        if (pick == GW'(i)) sd_lba[32*i +: 32] <= req_lba[32*i +: 32];
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed scenarios plus randomized traffic, checked
// each cycle against a transaction-level model of pending sets and ack schedules.
module tb_sd_req_arbiter;

  localparam int              NREQ  = 3;
  localparam int              TMO   = 1024;
  localparam logic [NREQ-1:0] WMASK = 3'b001;

  logic                 clk_sys = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_rd, req_wr, sd_ack, sd_rd, sd_wr, busy, done, err;
  logic [NREQ*32-1:0]   req_lba, sd_lba;
  logic [1:0]           grant;
  logic                 cpu_wait;

  sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO), .WAIT_MASK(WMASK)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_lba(req_lba), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .busy(busy), .done(done), .err(err), .grant(grant),
    .cpu_wait(cpu_wait)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  string phase = "reset";

  // Model: pending sets, last served drive, latched LBAs, one scheduled transfer.
  logic [NREQ-1:0] m_prd, m_pwr;
  int              m_last;
  logic [31:0]     m_lba [NREQ];
  bit              act, a_wr, a_abort;
  int              a_drv, a_s, a_off, a_end, a_rise, a_fall;

  // Stimulus knobs.
  bit              rand_mode = 0, noise_en = 0, k_noack = 0;
  int              k_dly = 1, k_hold = 2;
  logic [31:0]     lba_drv [NREQ];

  // Observations of the DUT, used by the directed checks.
  int              obs_drv[$];
  bit              obs_wr[$];
  int              n_done [NREQ];
  int              n_err  [NREQ];
  int              rise_cyc, done_cyc, err_cyc, fall_cyc;
  bit              seen_wait;
  logic [NREQ-1:0] prev_strobe;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_obs();
    obs_drv.delete();
    obs_wr.delete();
    for (int i = 0; i < NREQ; i++) begin
      n_done[i] = 0;
      n_err[i]  = 0;
    end
    seen_wait = 0;
  endtask

  task automatic model_reset();
    m_prd  = '0;
    m_pwr  = '0;
    m_last = NREQ - 1;
    act    = 0;
    for (int i = 0; i < NREQ; i++) m_lba[i] = '0;
    prev_strobe = '0;
    clear_obs();
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "/sd_rd"},    sd_rd,    '0);
    check({tag, "/sd_wr"},    sd_wr,    '0);
    check({tag, "/done"},     done,     '0);
    check({tag, "/err"},      err,      '0);
    check({tag, "/busy"},     busy,     '0);
    check({tag, "/cpu_wait"}, cpu_wait, 1'b0);
    check({tag, "/grant"},    grant,    NREQ - 1);
    check({tag, "/sd_lba"},   sd_lba,   '0);
  endtask

  // One clock cycle: arbitrate in the model, drive inputs, check outputs, update the model.
  task automatic step(input logic [NREQ-1:0] prd_p, input logic [NREQ-1:0] pwr_p);
    logic [NREQ-1:0]    exp_rd, exp_wr, exp_done, exp_err, strb, rise;
    logic [NREQ*32-1:0] exp_lba;
    logic [31:0]        arb_lba;
    bit                 arb, noack;
    int                 pick, d, h;
    @(posedge clk_sys);
    #1;
    cyc++;
    arb  = 0;
    pick = 0;
    if (!act) begin
      for (int k = 1; k <= NREQ; k++) begin
        int ix;
        ix = (m_last + k) % NREQ;
        if (!arb && (m_prd[ix] || m_pwr[ix])) begin
          arb  = 1;
          pick = ix;
        end
      end
    end
    if (arb) begin
      if (rand_mode) begin
        d = $urandom_range(0, 3); h = $urandom_range(1, 5); noack = 0;
      end else begin
        d = k_dly; h = k_hold; noack = k_noack;
      end
      act = 1; a_drv = pick; a_wr = !m_prd[pick]; a_s = cyc + 1; a_abort = noack;
      if (noack) begin
        a_rise = -1; a_fall = -1; a_off = a_s + TMO; a_end = a_s + TMO + 1;
      end else begin
        a_rise = a_s + d; a_fall = a_rise + h; a_off = a_rise; a_end = a_fall + 1;
        fall_cyc = a_fall;
      end
    end
    if (rand_mode) for (int i = 0; i < NREQ; i++) lba_drv[i] = $urandom();
    for (int i = 0; i < NREQ; i++) begin
      req_lba[32*i +: 32] = lba_drv[i];
      if (act && i == a_drv)
        sd_ack[i] = !a_abort && cyc >= a_rise && cyc < a_fall;
      else if (noise_en && !m_prd[i] && !m_pwr[i])
        sd_ack[i] = 1'($urandom_range(0, 1));
      else
        sd_ack[i] = 1'b0;
    end
    req_rd  = prd_p;
    req_wr  = pwr_p;
    arb_lba = lba_drv[pick];

    @(negedge clk_sys);
    exp_rd = '0; exp_wr = '0; exp_done = '0; exp_err = '0;
    if (act && cyc >= a_s && cyc <= a_off) begin
      if (a_wr) exp_wr[a_drv] = 1'b1;
      else      exp_rd[a_drv] = 1'b1;
    end
    if (act && cyc == a_end) begin
      if (a_abort) exp_err[a_drv]  = 1'b1;
      else         exp_done[a_drv] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) exp_lba[32*i +: 32] = m_lba[i];
    check({phase, "/sd_rd"},    sd_rd,    exp_rd);
    check({phase, "/sd_wr"},    sd_wr,    exp_wr);
    check({phase, "/done"},     done,     exp_done);
    check({phase, "/err"},      err,      exp_err);
    check({phase, "/busy"},     busy,     m_prd | m_pwr);
    check({phase, "/cpu_wait"}, cpu_wait, |((m_prd | m_pwr) & WMASK));
    check({phase, "/grant"},    grant,    m_last);
    check({phase, "/sd_lba"},   sd_lba,   exp_lba);

    strb = sd_rd | sd_wr;
    rise = strb & ~prev_strobe;
    prev_strobe = strb;
    for (int i = 0; i < NREQ; i++) begin
      if (rise[i]) begin
        obs_drv.push_back(i);
        obs_wr.push_back(sd_wr[i]);
        rise_cyc = cyc;
      end
      if (done[i]) begin n_done[i]++; done_cyc = cyc; end
      if (err[i])  begin n_err[i]++;  err_cyc  = cyc; end
    end
    if (cpu_wait) seen_wait = 1;

    if (act && cyc == a_end) begin
      if (a_wr) m_pwr[a_drv] = 1'b0;
      else      m_prd[a_drv] = 1'b0;
      act = 0;
    end
    m_prd = m_prd | prd_p;
    m_pwr = m_pwr | pwr_p;
    if (arb) begin
      m_last       = pick;
      m_lba[pick]  = arb_lba;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((act || (m_prd | m_pwr) != '0) && n < max) begin
      step('0, '0);
      n++;
    end
    if (n >= max) check({phase, "/idle_bound"}, 0, 1);
  endtask

  function automatic int obs_at(input int i);
    return (i < obs_drv.size()) ? obs_drv[i] : -1;
  endfunction

  function automatic int obs_wr_at(input int i);
    return (i < obs_wr.size()) ? int'(obs_wr[i]) : -1;
  endfunction

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int pulse_cyc, n;
    int rr_exp [5];
    logic [NREQ-1:0] rp, wp;
    rr_exp = '{0, 1, 2, 0, 1};
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; sd_ack = '0; req_lba = '0;
    for (int i = 0; i < NREQ; i++) lba_drv[i] = '0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Simultaneous reads on all drives right after reset, then drives 1 and 0 with grant at 2.
    phase = "rr"; k_dly = 1; k_hold = 2;
    for (int i = 0; i < NREQ; i++) lba_drv[i] = 32'h100 + i;
    step(3'b111, '0);
    wait_idle(200);
    check("rr/grant_after_pass", grant, 2);
    step(3'b011, '0);
    wait_idle(200);
    check("rr/count", obs_drv.size(), 5);
    for (int i = 0; i < 5; i++) check("rr/order", obs_at(i), rr_exp[i]);

    // Single HDD read with a long ack.
    phase = "hdd"; clear_obs();
    lba_drv[0] = 32'h1234; k_dly = 3; k_hold = 600;
    step(3'b001, '0);
    pulse_cyc = cyc;
    wait_idle(800);
    check("hdd/strobe_latency", rise_cyc - pulse_cyc, 2);
    check("hdd/done_after_fall", done_cyc - fall_cyc, 1);
    check("hdd/lba", sd_lba[31:0], 32'h1234);
    check("hdd/done_count", n_done[0], 1);
    check("hdd/seen_wait", seen_wait, 1);

    // Read and write together on drive 1: read first, then write.
    phase = "rdwr"; clear_obs(); k_dly = 2; k_hold = 3;
    step(3'b010, 3'b010);
    wait_idle(200);
    check("rdwr/count", obs_drv.size(), 2);
    check("rdwr/first_drv", obs_at(0), 1);
    check("rdwr/first_op", obs_wr_at(0), 0);
    check("rdwr/second_drv", obs_at(1), 1);
    check("rdwr/second_op", obs_wr_at(1), 1);
    check("rdwr/done_count", n_done[1], 2);

    // Floppy-only traffic never stalls the CPU.
    phase = "floppy"; clear_obs();
    repeat (3) begin
      step(3'b100, '0);  wait_idle(200);
      step('0, 3'b100);  wait_idle(200);
    end
    check("floppy/cpu_wait_seen", seen_wait, 0);
    check("floppy/done_count", n_done[2], 6);

    // Ack never arrives: abort after the timeout.
    phase = "timeout"; clear_obs(); k_noack = 1;
    step(3'b001, '0);
    wait_idle(TMO + 100);
    k_noack = 0;
    check("timeout/err_delay", err_cyc - rise_cyc, TMO + 1);
    check("timeout/err_count", n_err[0], 1);
    check("timeout/done_count", n_done[0], 0);
    step('0, '0);

    // Reset in the middle of a transfer with drives 1 and 2 pending.
    phase = "rst_mid"; clear_obs(); k_dly = 1; k_hold = 20;
    step(3'b001, '0);
    step(3'b110, '0);
    n = 0;
    while (!(act && cyc >= a_rise + 2) && n < 20) begin
      step('0, '0);
      n++;
    end
    check("rst_mid/pre_busy", busy, 3'b111);
    #2;
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; sd_ack = '0;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (30) step('0, '0);
    check("rst_mid/no_strobe", obs_drv.size(), 0);

    // Randomized traffic with ack noise on idle drives.
    phase = "random"; clear_obs(); rand_mode = 1; noise_en = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        rp[i] = ($urandom_range(0, 15) == 0);
        wp[i] = ($urandom_range(0, 15) == 0);
      end
      step(rp, wp);
    end
    rand_mode = 0; noise_en = 0; k_dly = 1; k_hold = 2;
    wait_idle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
